controle_de_venda: RTL and testbench
====================================

# controle_de_venda

Sales sequencer for the food machine. It samples the product-select buttons and arbitrates simultaneous presses. It checks the selected price against the current balance from the balance-control block, then debits that block through a req/ack handshake and pulses the dispense output for the chosen product. Insufficient balance produces a timed deny indication.

## Interface
- N_PROD, 4: number of products/select buttons (1..8).
- PRICES, {6'd25,6'd15,6'd10,6'd5}: flat vector, 6 bits per product, product i at [6i+5:6i]; units of 0.10 (balance unit).
- DISPENSE_CYCLES, 8: dispense pulse length in clocks (≥1).
- DENY_CYCLES, 4: deny pulse length in clocks (≥1).
- ACK_TIMEOUT, 16: max clocks waiting for debit_ack (≥2).

- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- sel_n  in  N_PROD  product buttons, active-low, already synchronised.
- saldo  in  6  current balance from the balance-control block.
- debit_ack  in  1  balance block has applied the debit.
- debit_req  out  1  debit request, level held until ack.
- debit_amt  out  6  amount to debit; valid whenever debit_req=1, else 0.
- dispense  out  N_PROD  one-hot dispense strobe.
- busy  out  1  high in any state other than IDLE.
- deny  out  1  insufficient balance / invalid selection indication.
- err  out  1  sticky debit-timeout flag (see Configuration).

## Operation
- Reset (reset=0) sets all outputs to 0, state to IDLE, product index to 0, counters to 0, and the sel_n history register to all-ones.
- Press detect: a press is a bit that is 0 now and 1 in the previous cycle (sel_n history register). Detection happens only in IDLE. Presses during any other state are dropped, not queued. The history register updates every cycle in every state.
- Arbitration: if multiple presses are detected in one cycle, the lowest index wins. Others are dropped.
- FSM states: IDLE, CHECK, DEBIT, DISPENSE, DENY.
  - IDLE: on press, latch index k and price P=PRICES[k], then go to CHECK.
  - CHECK (1 cycle): if P≠0 and P≤saldo, go to DEBIT. Otherwise go to DENY. The comparison is 6-bit unsigned.
  - DEBIT: debit_req=1 and debit_amt=P. When debit_ack=1 is sampled, go to DISPENSE. debit_ack is ignored outside DEBIT.
  - DISPENSE: dispense[k]=1 for exactly DISPENSE_CYCLES cycles, then go to IDLE.
  - DENY: deny=1 for exactly DENY_CYCLES cycles, then go to IDLE.
- The block never computes the new balance. The balance block owns it. saldo is sampled only in CHECK.
- Asserting reset mid-operation aborts immediately: all outputs go to 0 asynchronously, with no dispense and no pending req.

## Timing
- Press sampled at edge t: CHECK in cycle t+1. debit_req or deny first high in cycle t+2.
- debit_ack sampled high at edge a: debit_req low from cycle a+1, and dispense[k] high cycles a+1..a+DISPENSE_CYCLES.
- An ack in the same cycle debit_req first rises is accepted: one-cycle DEBIT.
- Earliest next press detection: the first IDLE cycle after DISPENSE/DENY ends. A button still held low then does not retrigger, because an edge is required.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- CONTROLE_DE_VENDA_TIMEOUT_EN defined:
  - A counter runs in DEBIT.
  - If no ack arrives within ACK_TIMEOUT cycles of debit_req rising, drop debit_req, set err=1, and go to DENY (deny for DENY_CYCLES). There is no dispense.
  - err stays 1 until reset.
- Macro undefined: DEBIT waits indefinitely, no timeout counter is built, and err is tied to 0.

## Test plan
- Reset: hold reset=0 with buttons active. All outputs are 0. Release reset: IDLE, busy=0.
- saldo=20, press product 1 (price 10), ack 3 cycles after req: debit_req for 3 cycles with debit_amt=10, then dispense=4'b0010 for 8 cycles, then busy=0.
- saldo=20, press product 3 (price 25): deny=1 for 4 cycles. debit_req and dispense stay 0.
- Press products 2 and 0 in the same cycle with saldo=50: product 0 is served (debit_amt=5, dispense[0]). A press on product 1 during DISPENSE is ignored.
- With TIMEOUT_EN, saldo=50, product 2, no ack: debit_req drops after 16 cycles, err=1 and stays set, deny for 4 cycles. Without the macro: debit_req stays high for over 100 cycles and err=0.
- Reset asserted in the third dispense cycle: dispense and busy go to 0 at once. After release, a held button does not trigger until it is released and pressed again.

Source files
------------

// File: rtl/controle_de_venda_if.sv
// controle_de_venda_if: button, balance, debit handshake and dispense signals of the sales sequencer
interface controle_de_venda_if #(parameter int N_PROD = 4);
    logic [N_PROD-1:0] sel_n;
    logic [5:0]        saldo;
    logic              debit_ack;
    logic              debit_req;
    logic [5:0]        debit_amt;
    logic [N_PROD-1:0] dispense;
    logic              busy;
    logic              deny;
    logic              err;
    modport master (output sel_n, saldo, debit_ack, input debit_req, debit_amt, dispense, busy, deny, err);
    modport slave (input sel_n, saldo, debit_ack, output debit_req, debit_amt, dispense, busy, deny, err);
endinterface

// File: rtl/controle_de_venda.sv
// controle_de_venda: vending sales sequencer (press arbitration, price check, debit handshake, dispense/deny pulses)
// Optional debit-ack timeout with sticky err is built when CONTROLE_DE_VENDA_TIMEOUT_EN is defined.
module controle_de_venda #(
    parameter int                  N_PROD          = 4,
    parameter logic [6*N_PROD-1:0] PRICES          = {6'd25, 6'd15, 6'd10, 6'd5},
    parameter int                  DISPENSE_CYCLES = 8,
    parameter int                  DENY_CYCLES     = 4,
    parameter int                  ACK_TIMEOUT     = 16
) (
    input logic                i_clk,
    input logic                i_rst_n,
    controle_de_venda_if.slave bus
);
    localparam int M1   = DISPENSE_CYCLES > DENY_CYCLES ? DISPENSE_CYCLES : DENY_CYCLES;
    localparam int MAXC = M1 > ACK_TIMEOUT ? M1 : ACK_TIMEOUT;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = N_PROD > 1 ? $clog2(N_PROD) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, DEBIT, DISPENSE, DENY} state_t;

    state_t            r_state, w_next;
    logic [N_PROD-1:0] r_hist, w_press, r_disp;
    logic              r_arm, w_hit, r_req, r_busy, r_deny;
    logic [IW-1:0]     r_idx, w_idx;
    logic [5:0]        r_price, r_amt;
    logic [CW-1:0]     r_cnt, w_cnt;
`ifdef CONTROLE_DE_VENDA_TIMEOUT_EN
    logic              r_err, w_timeout;
`endif

    // r_arm masks the first cycle after reset so a button held through reset is not seen as a press
    assign w_press = r_hist & ~bus.sel_n & {N_PROD{r_arm}};

    always_comb begin
        w_idx = '0;
        w_hit = 1'b0;
        for (int i = N_PROD - 1; i >= 0; i--) begin
            if (w_press[i]) begin
                w_idx = IW'(i);
                w_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_cnt  = '0;
`ifdef CONTROLE_DE_VENDA_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            IDLE:  w_next = w_hit ? CHECK : IDLE;
            CHECK: w_next = (r_price != 6'd0 && r_price <= bus.saldo) ? DEBIT : DENY;
            DEBIT: begin
                if (bus.debit_ack) w_next = DISPENSE;
`ifdef CONTROLE_DE_VENDA_TIMEOUT_EN
                else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    w_next    = DENY;
                    w_timeout = 1'b1;
                end else w_cnt = r_cnt + 1'b1;
`endif
            end
            DISPENSE: begin
                if (r_cnt == CW'(DISPENSE_CYCLES - 1)) w_next = IDLE;
                else w_cnt = r_cnt + 1'b1;
            end
            DENY: begin
                if (r_cnt == CW'(DENY_CYCLES - 1)) w_next = IDLE;
                else w_cnt = r_cnt + 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_hist  <= '1;
            r_arm   <= 1'b0;
            r_idx   <= '0;
            r_price <= '0;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_amt   <= '0;
            r_disp  <= '0;
            r_deny  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_hist  <= bus.sel_n;
            r_arm   <= 1'b1;
            r_state <= w_next;
            r_cnt   <= w_cnt;
            if (r_state == IDLE && w_hit) begin
                r_idx   <= w_idx;
                r_price <= PRICES[6*w_idx +: 6];
            end
            r_req  <= w_next == DEBIT;
            r_amt  <= (w_next == DEBIT) ? r_price : '0;
            r_disp <= (w_next == DISPENSE) ? N_PROD'(1) << r_idx : '0;
            r_deny <= w_next == DENY;
            r_busy <= w_next != IDLE;
        end
    end

`ifdef CONTROLE_DE_VENDA_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_err <= 1'b0;
        else r_err <= r_err | w_timeout;
    end
    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.debit_req = r_req;
    assign bus.debit_amt = r_amt;
    assign bus.dispense  = r_disp;
    assign bus.deny      = r_deny;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_controle_de_venda.sv
// tb_controle_de_venda: randomized sales against a per-transaction timeline model of the sequencer
module tb_controle_de_venda;
    localparam int DISP = 8;
    localparam int DNY  = 4;
    localparam int TO   = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    int   pr[4] = '{5, 10, 15, 25};

    controle_de_venda_if #(.N_PROD(4)) vif ();

    controle_de_venda #(
        .N_PROD(4),
        .PRICES({6'd25, 6'd15, 6'd10, 6'd5}),
        .DISPENSE_CYCLES(DISP),
        .DENY_CYCLES(DNY),
        .ACK_TIMEOUT(TO)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(vif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs();
        return {18'd0, vif.busy, vif.debit_req, vif.deny, vif.err, vif.debit_amt, vif.dispense};
    endfunction

    function automatic logic [31:0] pack(bit busy, bit req, bit deny, bit err, int amt, int disp);
        return {18'd0, busy, req, deny, err, 6'(amt), 4'(disp)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h ({busy,req,deny,err,amt,disp})", tag, got, exp);
        end
    endtask

    // One sale: the model derives the expected output timeline from price, balance and ack delay
    task automatic run_sale(input int id, input logic [3:0] pat, input int bal, input int d, input bit hold, input bit noise);
        int k;
        int p;
        bit ok;
        int last;
        bit req;
        k = 0;
        for (int i = 3; i >= 0; i--) if (pat[i]) k = i;
        p = pr[k];
        ok = p != 0 && p <= bal;
        last = ok ? 2 + d + DISP : 1 + DNY;
        @(negedge clk);
        vif.sel_n = '1;
        vif.debit_ack = 1'b0;
        vif.saldo = 6'($urandom);
        @(negedge clk);
        check($sformatf("idle%0d", id), obs(), 32'd0);
        vif.sel_n = ~pat;
        vif.debit_ack = 1'($urandom);
        vif.saldo = 6'($urandom);
        for (int n = 1; n <= last + 2; n++) begin
            @(negedge clk);
            req = ok && n >= 2 && n <= 2 + d;
            check($sformatf("sale%0d_n%0d", id, n), obs(),
                  pack(n <= last, req, !ok && n >= 2 && n <= last, 1'b0, req ? p : 0,
                       (ok && n >= 3 + d && n <= last) ? (1 << k) : 0));
            vif.saldo = (n == 1) ? 6'(bal) : 6'($urandom);
            vif.debit_ack = (ok && n == 2 + d) ? 1'b1 : (ok && n >= 2 && n < 2 + d) ? 1'b0 : 1'($urandom);
            vif.sel_n = hold ? ~pat : (noise && n < last) ? 4'($urandom) : 4'hf;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vif.sel_n = '0;
        vif.saldo = 6'd50;
        vif.debit_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset", obs(), 32'd0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("held_after_reset", obs(), 32'd0);
        end
        run_sale(1, 4'b0010, 20, 2, 1'b0, 1'b0);
        run_sale(2, 4'b1000, 20, 0, 1'b0, 1'b0);
        run_sale(3, 4'b0101, 50, 1, 1'b0, 1'b1);
        run_sale(4, 4'b0100, 15, 0, 1'b1, 1'b0);
        run_sale(5, 4'b0100, 14, 0, 1'b0, 1'b1);
        run_sale(6, 4'b0001, 0, 0, 1'b0, 1'b0);
        run_sale(7, 4'b1000, 63, 4, 1'b1, 1'b1);
        // abort in the third dispense cycle with the button still held
        @(negedge clk);
        vif.sel_n = '1;
        vif.debit_ack = 1'b0;
        vif.saldo = 6'd20;
        @(negedge clk);
        vif.sel_n = 4'b1101;
        @(negedge clk);
        @(negedge clk);
        vif.debit_ack = 1'b1;
        @(negedge clk);
        vif.debit_ack = 1'b0;
        check("abort_disp1", obs(), pack(1, 0, 0, 0, 0, 2));
        @(negedge clk);
        @(negedge clk);
        check("abort_disp3", obs(), pack(1, 0, 0, 0, 0, 2));
        #2 rst_n = 1'b0;
        #1 check("abort_async", obs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort_held", obs(), 32'd0);
        end
        run_sale(8, 4'b0010, 20, 0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++)
            run_sale(100 + i, 4'($urandom_range(1, 15)), $urandom_range(0, 63), $urandom_range(0, 4),
                     1'($urandom), 1'($urandom));
        @(negedge clk);
        vif.sel_n = '1;
        vif.debit_ack = 1'b0;
        vif.saldo = 6'd50;
        @(negedge clk);
        vif.sel_n = 4'b1011;
`ifdef CONTROLE_DE_VENDA_TIMEOUT_EN
        for (int n = 1; n <= 23; n++) begin
            @(negedge clk);
            check($sformatf("timeout_n%0d", n), obs(),
                  pack(n <= 21, n >= 2 && n <= 17, n >= 18 && n <= 21, n >= 18, (n >= 2 && n <= 17) ? 15 : 0, 0));
            vif.sel_n = '1;
        end
`else
        for (int n = 1; n <= 112; n++) begin
            @(negedge clk);
            check($sformatf("wait_ack_n%0d", n), obs(), pack(1, n >= 2, 0, 0, n >= 2 ? 15 : 0, 0));
            vif.sel_n = '1;
        end
`endif
        rst_n = 1'b0;
        @(negedge clk);
        check("final_reset", obs(), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
